// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed seven-segment scanner for a 0..19 BCD value.
// A prescaler divides clk into digit slots; a new value is staged in a
// pending register and only copied to the display register at a frame
// boundary (end of the tens slot), so a frame never shows two different values.
// Segments and anodes are active-low and registered from the post-edge slot
// and display value.

module bcd_display_scanner #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] bcd_in,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [1:0] AN_NONE  = 2'b11;
    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

    typedef enum logic {
        SLOT_UNITS = 1'b0,
        SLOT_TENS  = 1'b1
    } slot_t;

    // Active-low segment pattern (g..a) for one BCD digit; 10..15 show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    // A units digit above 9 cannot come from a valid binary-to-BCD conversion.
    function automatic logic units_invalid(input logic [3:0] digit);
        return (digit > 4'd9);
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             tick_s;
    slot_t            slot_r;
    slot_t            slot_nxt_s;
    logic             boundary_s;
    logic             pending_r;
    logic             pending_nxt_s;
    logic [4:0]       pending_reg_r;
    logic [4:0]       pending_reg_nxt_s;
    logic [4:0]       disp_r;
    logic [4:0]       disp_nxt_s;
    logic [6:0]       seg_nxt_s;
    logic [1:0]       an_nxt_s;
    logic             err_nxt_s;

    // Prescaler: count 0..REFRESH_DIV-1 and flag the last count of each slot.
    always_comb begin
        tick_s    = 1'b0;
        cnt_nxt_s = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_MAX) begin
            tick_s    = 1'b1;
            cnt_nxt_s = '0;
        end else begin
            tick_s    = 1'b0;
        end
    end

    // Slot sequencer next state: alternate units/tens on every tick.
    always_comb begin
        slot_nxt_s = slot_r;
        case (slot_r)
            SLOT_UNITS: begin
                if (tick_s) begin
                    slot_nxt_s = SLOT_TENS;
                end else begin
                    slot_nxt_s = SLOT_UNITS;
                end
            end
            SLOT_TENS: begin
                if (tick_s) begin
                    slot_nxt_s = SLOT_UNITS;
                end else begin
                    slot_nxt_s = SLOT_TENS;
                end
            end
            default: slot_nxt_s = SLOT_UNITS;
        endcase
    end

    // The last cycle of the tens slot ends a frame.
    assign boundary_s = tick_s && (slot_r == SLOT_TENS);

    // Staging: the boundary moves the pre-edge pending value to the display,
    // while a coincident load refills the stage and keeps it pending.
    always_comb begin
        pending_nxt_s     = pending_r;
        pending_reg_nxt_s = pending_reg_r;
        disp_nxt_s        = disp_r;
        if (boundary_s && pending_r) begin
            disp_nxt_s    = pending_reg_r;
            pending_nxt_s = 1'b0;
        end else begin
            disp_nxt_s    = disp_r;
        end
        if (load) begin
            pending_reg_nxt_s = bcd_in;
            pending_nxt_s     = 1'b1;
        end else begin
            pending_reg_nxt_s = pending_reg_r;
        end
    end

    // Output decode from the slot and display value that hold after this edge.
    always_comb begin
        seg_nxt_s = SEG_OFF;
        an_nxt_s  = AN_NONE;
        err_nxt_s = units_invalid(disp_nxt_s[3:0]);
        case (slot_nxt_s)
            SLOT_UNITS: begin
                an_nxt_s  = AN_UNITS;
                seg_nxt_s = seg_decode(disp_nxt_s[3:0]);
            end
            SLOT_TENS: begin
                if (blank_lz && !disp_nxt_s[4]) begin
                    an_nxt_s  = AN_NONE;
                    seg_nxt_s = SEG_OFF;
                end else begin
                    an_nxt_s  = AN_TENS;
                    seg_nxt_s = seg_decode({3'b000, disp_nxt_s[4]});
                end
            end
            default: begin
                an_nxt_s  = AN_NONE;
                seg_nxt_s = SEG_OFF;
            end
        endcase
    end

    // Slot sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r <= SLOT_UNITS;
        end else begin
            slot_r <= slot_nxt_s;
        end
    end

    // Prescaler, staging and display registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r         <= '0;
            pending_r     <= 1'b0;
            pending_reg_r <= 5'b00000;
            disp_r        <= 5'b00000;
        end else begin
            cnt_r         <= cnt_nxt_s;
            pending_r     <= pending_nxt_s;
            pending_reg_r <= pending_reg_nxt_s;
            disp_r        <= disp_nxt_s;
        end
    end

    // Registered display outputs; reset turns every digit off.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= AN_NONE;
            err <= 1'b0;
        end else begin
            seg <= seg_nxt_s;
            an  <= an_nxt_s;
            err <= err_nxt_s;
        end
    end

    bcd_display_scanner_chk u_chk (
        .clk (clk),
        .rst (rst),
        .seg (seg),
        .an  (an)
    );

endmodule

// Output-side invariants of the scanner: never both anodes on, and a
// dark digit position always carries dark segments.
module bcd_display_scanner_chk (
    input logic       clk,
    input logic       rst,
    input logic [6:0] seg,
    input logic [1:0] an
);

    logic armed_r;

    // Arm the checks once a reset has initialised the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Output invariants, checked once per clock after the first reset.
    always @(posedge clk) begin
        if (armed_r) begin
            assert (an != 2'b00);
            assert ((an != 2'b11) || (seg == 7'b1111111));
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner with REFRESH_DIV=4: a cycle model
// pushes the expected {seg,an,err} each time stimulus is driven; the value is
// popped and compared just after the clock edge. Directed checks on the
// observed display history cover the frame-level scenarios.

module tb_bcd_display_scanner;

    localparam int DIV = 4;
    localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                        7'b0110000, 7'b0011001, 7'b0010010,
                                        7'b0000010, 7'b1111000, 7'b0000000,
                                        7'b0010000};
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] OFF  = 7'b1111111;
    localparam logic [1:0] AN_SEQ [11] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01,
                                           2'b01, 2'b01, 2'b10, 2'b10, 2'b10,
                                           2'b10};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       blank_lz = 1'b0;
    logic [4:0] bcd_in = 5'b00000;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int errors = 0;
    int checks = 0;

    logic [9:0] exp_q [$];

    int         m_cnt = 0;
    logic       m_sel = 1'b0;
    logic       m_pend = 1'b0;
    logic [4:0] m_preg = 5'b00000;
    logic [4:0] m_disp = 5'b00000;

    logic [6:0] obs_seg;
    logic [1:0] obs_an;
    logic       obs_err;
    logic [6:0] last_units;
    logic [6:0] last_tens;
    int         units_hits [16];
    int         n_an01;
    int         n_an11;
    logic       err_or;

    always #5 clk = ~clk;

    bcd_display_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd_in   (bcd_in),
        .load     (load),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .err      (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int seg_to_digit(input logic [6:0] s);
        for (int i = 0; i < 10; i++) begin
            if (PAT[i] == s) return i;
        end
        if (s == DASH) return 10;
        return 15;
    endfunction

    // Expected outputs from the model's post-edge slot and display value.
    function automatic logic [9:0] model_out();
        logic [6:0] s;
        logic [1:0] a;
        logic       e;
        e = (m_disp[3:0] > 4'd9);
        if (!m_sel) begin
            a = 2'b10;
            s = e ? DASH : PAT[int'(m_disp[3:0])];
        end else if (blank_lz && !m_disp[4]) begin
            a = 2'b11;
            s = OFF;
        end else begin
            a = 2'b01;
            s = PAT[int'(m_disp[4])];
        end
        return {s, a, e};
    endfunction

    task automatic clear_stats();
        for (int i = 0; i < 16; i++) units_hits[i] = 0;
        n_an01 = 0;
        n_an11 = 0;
        err_or = 1'b0;
    endtask

    task automatic step(input logic r, input logic ld, input logic [4:0] d);
        logic [9:0] e;
        logic       tick;
        logic       bnd;
        rst    = r;
        load   = ld;
        bcd_in = d;
        if (r) begin
            m_cnt = 0; m_sel = 1'b0; m_pend = 1'b0; m_preg = 5'b00000; m_disp = 5'b00000;
            e = {OFF, 2'b11, 1'b0};
        end else begin
            tick = (m_cnt == DIV - 1);
            bnd  = tick && m_sel;
            if (bnd && m_pend) begin
                m_disp = m_preg;
                m_pend = 1'b0;
            end
            if (ld) begin
                m_preg = d;
                m_pend = 1'b1;
            end
            if (tick) begin
                m_sel = ~m_sel;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            e = model_out();
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_seg = seg;
        obs_an  = an;
        obs_err = err;
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            check_val("sb_out", 32'({obs_seg, obs_an, obs_err}), 32'(exp_q.pop_front()));
        end
        if (obs_an == 2'b10) begin
            last_units = obs_seg;
            units_hits[seg_to_digit(obs_seg)]++;
        end
        if (obs_an == 2'b01) begin
            last_tens = obs_seg;
            n_an01++;
        end
        if (obs_an == 2'b11) n_an11++;
        err_or = err_or | obs_err;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'b00000);
    endtask

    // Advance until the next cycle starts a new frame in the units slot.
    task automatic align_frame();
        for (int i = 0; i < 16 && !(m_sel == 1'b0 && m_cnt == 0); i++) idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_stats();
        // Reset, then the first frames with zero displayed.
        step(1'b1, 1'b0, 5'b00000);
        step(1'b1, 1'b0, 5'b00000);
        check_val("reset_out", 32'({obs_seg, obs_an, obs_err}), 32'({OFF, 2'b11, 1'b0}));
        for (int i = 0; i < 11; i++) begin
            idle(1);
            if (i == 0) check_val("first_edge", 32'({obs_seg, obs_an, obs_err}), 32'({7'b1000000, 2'b10, 1'b0}));
            check_val("an_seq", 32'(obs_an), 32'(AN_SEQ[i]));
            check_val("zero_seg", 32'(obs_seg), 32'(PAT[0]));
        end

        // Leading-zero blanking of the tens slot.
        blank_lz = 1'b1;
        clear_stats();
        idle(8);
        check_val("blank_an01", 32'(n_an01), 32'd0);
        check_val("blank_an11", 32'(n_an11), 32'd4);
        blank_lz = 1'b0;

        // Load mid units slot: held until the boundary, then "15".
        align_frame();
        idle(1);
        step(1'b0, 1'b1, 5'b10101);
        idle(1);
        check_val("load_hold", 32'(last_units), 32'(PAT[0]));
        idle(16);
        check_val("load_units", 32'(last_units), 32'(PAT[5]));
        check_val("load_tens", 32'(last_tens), 32'(PAT[1]));

        // Two loads in one frame: last one wins.
        align_frame();
        clear_stats();
        step(1'b0, 1'b1, 5'b00011);
        idle(1);
        step(1'b0, 1'b1, 5'b00111);
        idle(16);
        check_val("ovw_no3", 32'(units_hits[3]), 32'd0);
        check_val("ovw_units", 32'(last_units), 32'(PAT[7]));
        check_val("ovw_err", 32'(err_or), 32'd0);

        // Invalid units digit shows a dash and raises err until replaced.
        align_frame();
        step(1'b0, 1'b1, 5'b01100);
        idle(16);
        check_val("inv_dash", 32'(last_units), 32'(DASH));
        check_val("inv_err", 32'(obs_err), 32'd1);
        step(1'b0, 1'b1, 5'b00010);
        check_val("inv_err_hold", 32'(obs_err), 32'd1);
        idle(16);
        check_val("inv_err_clr", 32'(obs_err), 32'd0);
        check_val("inv_units2", 32'(last_units), 32'(PAT[2]));

        // Load on the exact boundary edge: old pending shown one frame first.
        align_frame();
        step(1'b0, 1'b1, 5'b00001);
        for (int i = 0; i < 16 && !(m_sel == 1'b1 && m_cnt == DIV - 1); i++) idle(1);
        step(1'b0, 1'b1, 5'b01001);
        check_val("bnd_first", 32'({obs_seg, obs_an}), 32'({PAT[1], 2'b10}));
        clear_stats();
        idle(7);
        check_val("bnd_no9", 32'(units_hits[9]), 32'd0);
        check_val("bnd_ones", 32'(units_hits[1]), 32'd3);
        idle(1);
        check_val("bnd_nine", 32'({obs_seg, obs_an}), 32'({PAT[9], 2'b10}));

        // Reset during the tens slot with a value pending (and a load asserted).
        align_frame();
        step(1'b0, 1'b1, 5'b00110);
        for (int i = 0; i < 16 && m_sel != 1'b1; i++) idle(1);
        step(1'b1, 1'b1, 5'b00110);
        check_val("mid_rst_out", 32'({obs_seg, obs_an}), 32'({OFF, 2'b11}));
        clear_stats();
        idle(16);
        check_val("mid_rst_no6", 32'(units_hits[6]), 32'd0);
        check_val("mid_rst_units", 32'(last_units), 32'(PAT[0]));
        check_val("mid_rst_tens", 32'(last_tens), 32'(PAT[0]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clk cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL have one clock and a synchronous, active-high reset; there are no other clock or reset inputs.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port bcd_in  input  5  bit 4 = tens digit (0/1), bits 3:0 = units digit, from the 4-bit binary-to-BCD converter.
REQ-006 SHALL have port load  input  1  one-cycle strobe; bcd_in is captured on a clk edge with load=1.
REQ-007 SHALL have port blank_lz  input  1  1 = suppress a tens digit of 0; sampled every cycle.
REQ-008 SHALL have port seg  output  7  active-low segments, seg[0]=a ... seg[6]=g, registered.
REQ-009 SHALL have port an  output  2  active-low digit enables, an[0]=units, an[1]=tens, registered.
REQ-010 SHALL have port err  output  1  high while the displayed units digit is greater than 9, registered.

Function
REQ-011 SHALL keep prescaler cnt, counting 0..REFRESH_DIV-1 and wrapping to 0.
- tick = (cnt == REFRESH_DIV-1).
REQ-012 SHALL keep digit_sel (0=units, 1=tens), which toggles on every tick.
REQ-013 SHALL write bcd_in into pending_reg and set pending=1 on a load cycle.
- A load while pending=1 overwrites pending_reg; last load wins.
REQ-014 SHALL treat a tick with digit_sel=1 as the frame boundary.
- At the boundary, if pending=1: disp_reg <= pending_reg, pending <= 0.
- disp_reg SHALL change at no other time (no tearing).
REQ-015 SHALL handle load coincident with a frame boundary as follows:
- The boundary transfers the pre-edge pending_reg, if pending was 1.
- The new bcd_in goes into pending_reg and pending stays 1.
- The new value is displayed at the following boundary.
REQ-016 SHALL drive outputs each cycle from the post-edge digit_sel and disp_reg, giving one cycle of latency.
REQ-017 SHALL use these digit slots:
- Units slot: an=2'b10.
- Tens slot: an=2'b01.
REQ-018 SHALL use standard active-low patterns for digits 0-9, with 0=7'b1000000 and 1=7'b1111001.
REQ-019 SHALL display a units value of 10-15 as a dash (seg=7'b0111111) and set err=1 for every cycle that disp_reg[3:0] > 9.
REQ-020 SHALL blank the tens slot when blank_lz=1 and disp_reg[4]=0: an=2'b11 and seg=7'b1111111 for that slot.
REQ-021 SHALL never assert both anodes simultaneously; an=2'b00 is illegal.

Reset
REQ-022 SHALL apply the following on a clk edge with rst=1:
- cnt=0, digit_sel=0, pending=0, pending_reg=0, disp_reg=0.
- Outputs: seg=7'b1111111, an=2'b11, err=0.
REQ-023 SHALL give rst priority over load and tick, and discard a pending value when rst is asserted mid-frame.
REQ-024 SHALL, on the first edge after rst deasserts, output an=2'b10, seg=7'b1000000, err=0.

Verification (REFRESH_DIV=4)
REQ-025 SHALL verify reset-to-first-frame:
- Stimulus: rst for 2 cycles, then released.
- Response: an cycles 10,10,10,10,01,01,01,01 repeatedly.
- seg=7'b1000000 in both slots with blank_lz=0.
- With blank_lz=1, the tens slot gives an=2'b11.
REQ-026 SHALL verify load synchronisation:
- Stimulus: load bcd_in=5'b1_0101 (15) mid units slot.
- Response: display unchanged until the next frame boundary.
- Then units slot seg=7'b0010010 ("5"), tens slot seg=7'b1111001 ("1").
REQ-027 SHALL verify load overwrite:
- Stimulus: load 5'b0_0011, then 5'b0_0111 two cycles later, both in the same frame.
- Response: only 7 is ever displayed.
- err stays 0.
REQ-028 SHALL verify an invalid units digit:
- Stimulus: load 5'b0_1100.
- Response: after the boundary, units slot seg=7'b0111111 and err=1.
- A later load of 5'b0_0010 clears err at the following boundary.
REQ-029 SHALL verify load coincident with the boundary:
- Stimulus: pending 5'b0_0001, and load 5'b0_1001 on the exact boundary edge.
- Response: 1 is displayed for one full frame, then 9.
REQ-030 SHALL verify reset mid-operation:
- Stimulus: rst asserted during the tens slot with pending=1.
- Response: seg=7'b1111111, an=2'b11 on that edge.
- After release, 0 is displayed and the pending value is never shown.
